// File: rtl/regfile_dump_reader.sv
// Walks a register file read port from FIRST_REG to LAST_REG and streams
// each (address, data) word out over a valid/ready handshake.
module regfile_dump_reader #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND
  } state_t;

  state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ra        <= '0;
      out_addr  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // RA is left where it was; only the stream is cancelled
        state     <= IDLE;
        out_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              ra    <= FIRST_A;
              busy  <= 1'b1;
              state <= READ;
            end
          end
          READ: begin
            out_data  <= rd;
            out_addr  <= ra;
            out_valid <= 1'b1;
            state     <= SEND;
          end
          SEND: begin
            if (out_valid && out_ready) begin
              out_valid <= 1'b0;
              if (ra == LAST_A) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                ra    <= ra + ADDR_W'(1);
                state <= READ;
              end
            end
          end
          default: begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: scoreboard of expected dump words filled
// from a register-array model, popped by a monitor on each handshake.
module tb_regfile_dump_reader;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int FIRST = 0;
  localparam int LAST = 31;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] ra;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] rd;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          busy;
  logic          done;
  logic [DW-1:0] regs [32];

  logic          start2 = 1'b0;
  logic          abort2 = 1'b0;
  logic          ready2 = 1'b0;
  logic [AW-1:0] ra2;
  logic [AW-1:0] addr2;
  logic [DW-1:0] rd2;
  logic [DW-1:0] data2;
  logic          valid2;
  logic          busy2;
  logic          done2;
  logic [DW-1:0] regs2 [32];

  assign rd  = (ra == '0) ? '0 : regs[ra];
  assign rd2 = (ra2 == '0) ? '0 : regs2[ra2];

  regfile_dump_reader #(
    .ADDR_W(AW), .DATA_W(DW), .FIRST_REG(FIRST), .LAST_REG(LAST)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .ra(ra), .rd(rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .busy(busy), .done(done)
  );

  regfile_dump_reader #(
    .ADDR_W(AW), .DATA_W(DW), .FIRST_REG(5), .LAST_REG(7)
  ) u_sub (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .ra(ra2), .rd(rd2), .out_valid(valid2), .out_ready(ready2),
    .out_addr(addr2), .out_data(data2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } word_t;

  word_t exp_q[$];
  bit    m_busy = 1'b0;
  bit    m_done = 1'b0;
  int    delivered = 0;
  int    errors = 0;
  int    checks = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: inputs and outputs are stable at the falling edge, so the
  // values seen here decide what the next rising edge does.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_busy = 1'b0;
        m_done = 1'b0;
      end
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 64'(out_valid), 64'd0);
        end else begin
          chk("out_addr", 64'(out_addr), 64'(exp_q[0].a));
          chk("out_data", 64'(out_data), 64'(exp_q[0].d));
        end
      end
      m_done = 1'b0;
      if (!rst_n) begin
        m_busy = 1'b0;
      end else if (abort) begin
        exp_q.delete();
        m_busy = 1'b0;
      end else if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1;
          for (int i = FIRST; i <= LAST; i++)
            exp_q.push_back({AW'(i), (i == 0) ? '0 : regs[i]});
        end
      end else if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        delivered++;
        if (exp_q.size() == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_done(string name, int budget, bit rnd_ready,
                           bit rnd_start);
    int n;
    n = 0;
    while (!done && n < budget) begin
      if (rnd_ready) out_ready = ($urandom % 3) == 0;
      if (rnd_start) start = ($urandom % 5) == 0;
      cycle();
      n++;
    end
    start = 1'b0;
    if (!done) chk(name, 64'd0, 64'd1);
  endtask

  initial begin
    int n;
    int d0;
    int got;
    int dones;
    word_t got_w [3];

    for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;
    regs[0] = 32'hDEADBEEF;
    for (int i = 0; i < 32; i++) regs2[i] = 32'hFFFF0000 + i;
    regs2[5] = 32'hA;
    regs2[6] = 32'hB;
    regs2[7] = 32'hC;

    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ra", 64'(ra), 64'd0);
    chk("rst_addr", 64'(out_addr), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // full dump with ready held high
    out_ready = 1'b1;
    d0 = delivered;
    start = 1'b1;
    cycle();
    start = 1'b0;
    n = 1;
    while (!done && n < 200) begin
      cycle();
      n++;
    end
    chk("done_latency", 64'(n), 64'd65);
    chk("full_count", 64'(delivered - d0), 64'd32);
    cycle();

    // same dump with ready asserted about one cycle in three
    d0 = delivered;
    pulse_start();
    wait_done("stall_timeout", 600, 1'b1, 1'b0);
    chk("stall_count", 64'(delivered - d0), 64'd32);
    out_ready = 1'b1;
    cycle();

    // narrow window instance: registers 5..7
    ready2 = 1'b1;
    start2 = 1'b1;
    cycle();
    start2 = 1'b0;
    got = 0;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (valid2 && ready2) begin
        if (got < 3) got_w[got] = {addr2, data2};
        got++;
      end
      if (done2) dones++;
      cycle();
    end
    chk("sub_count", 64'(got), 64'd3);
    chk("sub_done", 64'(dones), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("sub_addr", 64'(got_w[i].a), 64'(5 + i));
      chk("sub_data", 64'(got_w[i].d), 64'(32'hA + i));
    end

    // abort while word 10 is being handshaked
    out_ready = 1'b1;
    d0 = delivered;
    pulse_start();
    n = 0;
    while (!(out_valid && out_addr == AW'(10)) && n < 100) begin
      cycle();
      n++;
    end
    chk("abort_reach", 64'(out_addr), 64'd10);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_count", 64'(delivered - d0), 64'd10);
    dones = 0;
    for (int c = 0; c < 5; c++) begin
      if (done) dones++;
      cycle();
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    d0 = delivered;
    pulse_start();
    wait_done("restart_timeout", 200, 1'b0, 1'b0);
    chk("restart_count", 64'(delivered - d0), 64'd32);
    cycle();

    // asynchronous reset in the middle of a dump
    pulse_start();
    n = 0;
    while (!(out_valid && out_addr == AW'(20)) && n < 100) begin
      cycle();
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_ra", 64'(ra), 64'd0);
    cycle();
    cycle();
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      if (done || out_valid || busy) dones++;
      cycle();
    end
    chk("arst_no_resume", 64'(dones), 64'd0);

    // randomized dumps with random ready and stray start pulses
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      d0 = delivered;
      pulse_start();
      wait_done("rand_timeout", 600, 1'b1, 1'b1);
      chk("rand_count", 64'(delivered - d0), 64'd32);
      out_ready = 1'b1;
      cycle();
      cycle();
    end

    // start held high: the second dump begins in the DONE cycle
    out_ready = 1'b1;
    d0 = delivered;
    start = 1'b1;
    n = 0;
    while (!done && n < 200) begin
      cycle();
      n++;
    end
    cycle();
    chk("held_restart_busy", 64'(busy), 64'd1);
    start = 1'b0;
    wait_done("held_timeout", 200, 1'b0, 1'b0);
    chk("held_count", 64'(delivered - d0), 64'd64);
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Sequential reader that walks the register file's read port from register FIRST_REG to LAST_REG and streams each (address, data) pair out over a valid/ready handshake. It is the read-side counterpart of the writeback path into the register file. It sits beside the CPU core and borrows one asynchronous read port (address out, data in) while the core is halted. It is used for end-of-test register dumps and debug readout.

## Interface

Parameters:
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- FIRST_REG, 0, first register index dumped
- LAST_REG, 31, last register index dumped; must satisfy FIRST_REG <= LAST_REG < 2**ADDR_W

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  reset; one clock; reset is asynchronous and active-low
- START  in  1  begin a dump; sampled only in IDLE
- ABORT  in  1  synchronous abort; returns to IDLE from any state
- RA  out  ADDR_W  read address driven to the register file read port
- RD  in  DATA_W  combinational read data returned for RA (register 0 reads as 0)
- OUT_VALID  out  1  OUT_ADDR/OUT_DATA hold a valid word
- OUT_READY  in  1  consumer accepts the word when OUT_VALID && OUT_READY at a rising edge
- OUT_ADDR  out  ADDR_W  register index of the current word
- OUT_DATA  out  DATA_W  register contents of the current word
- BUSY  out  1  high in any state other than IDLE
- DONE  out  1  one-cycle pulse after the last word is accepted

## Operation

- Reset (RST_N low, asynchronous): state IDLE; RA, OUT_ADDR and OUT_DATA = 0; OUT_VALID, BUSY and DONE = 0.
- FSM states are IDLE, READ and SEND.
- IDLE:
  - START=1 → RA <= FIRST_REG, next state READ.
  - Otherwise hold.
  - DONE is cleared on every edge unless it is being set.
- READ: OUT_DATA <= RD, OUT_ADDR <= RA, OUT_VALID <= 1, next state SEND.
- SEND, with OUT_VALID && OUT_READY:
  - If RA == LAST_REG: OUT_VALID <= 0, DONE <= 1, next state IDLE.
  - Else: RA <= RA + 1, OUT_VALID <= 0, next state READ.
- SEND without OUT_READY: hold. OUT_ADDR and OUT_DATA stay stable while OUT_VALID is high, even if RD changes.
- ABORT=1 in any state:
  - Next state IDLE, OUT_VALID <= 0, DONE stays 0, RA unchanged.
  - ABORT takes priority over START and over a handshake in the same cycle.
  - A word whose handshake coincides with ABORT counts as not delivered.
- START while BUSY is ignored. START in the same cycle DONE is high is accepted, because the FSM is already in IDLE.
- RA increments with no wrap-around. It never exceeds LAST_REG, so LAST_REG = 2**ADDR_W-1 needs no extra width.
- Words delivered per dump = LAST_REG - FIRST_REG + 1, in ascending address order, with no gaps or duplicates.

## Timing

- START high at edge t:
  - BUSY=1 and RA=FIRST_REG after t.
  - RD is sampled at t+1.
  - OUT_VALID=1 after t+1.
- Per word: minimum 2 cycles (READ + SEND), so back-to-back throughput is 1 word / 2 cycles with OUT_READY held high.
- Full dump of 32 registers with OUT_READY tied high: START edge t → last handshake at edge t+64 → DONE high for the cycle after t+64.
- Register file writes occur on the falling edge. The READ-state sample at the next rising edge returns the newly written value. The block does not stall the core; the dump is coherent only if the core is halted.
- RA is registered (no combinational path START→RA). OUT_* are registered; there is no combinational OUT_READY→OUT_VALID path.
- RST_N asserted mid-dump clears all outputs immediately (asynchronous). After deassertion the FSM restarts in IDLE and no DONE is produced for the interrupted dump.

## Test plan

- Preload reg i = 0x100+i (i=1..31), OUT_READY=1, pulse START → 32 words with addresses 0..31, word 0 data 0, word i data 0x100+i; DONE pulses once, 65 cycles after START; BUSY high exactly until DONE.
- Same preload, OUT_READY toggling 1-of-3 cycles → identical 32-word sequence; OUT_ADDR/OUT_DATA unchanged during every stall cycle.
- FIRST_REG=5, LAST_REG=7, regs 5..7 = 0xA,0xB,0xC → exactly 3 words (5,0xA),(6,0xB),(7,0xC), then DONE.
- ABORT asserted while at address 10 with OUT_VALID high and OUT_READY high → word 10 not counted; OUT_VALID=0 and BUSY=0 next cycle, no DONE; a new START restarts at address 0.
- RST_N pulled low at address 20 (asynchronous, mid-cycle) → OUT_VALID, BUSY and DONE = 0 and RA = 0 before the next edge; the dump is not resumed after release.
- START held high continuously → a new dump begins in the DONE cycle; START pulses during BUSY have no effect on the address sequence.
